vscale_htif_host: RTL and testbench

Host-side HTIF master that sits directly upstream of `vscale_hasti_wrapper`'s HTIF PCR port in `vscale_top`, replacing the tied-off `htif_pcr_*` drives. It serialises host CSR read/write commands onto the PCR request/response channel. In the background it polls the `tohost` CSR, latches test completion, and writes `tohost` back to zero.

---
 rtl/vscale_htif_host_pkg.sv | 24 ++
 rtl/vscale_htif_poll_timer.sv | 37 +++
 rtl/vscale_htif_host.sv | 194 +++++++++++++++++++
 tb/tb_vscale_htif_host.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vscale_htif_host_pkg.sv
// Shared definitions for the host-side HTIF master.
// Holds the CSR/PCR widths, the default tohost CSR address, the poll timer
// width and the FSM state type used by vscale_htif_host.
package vscale_htif_host_pkg;

  localparam int CSR_ADDR_WIDTH   = 12;
  localparam int HTIF_PCR_WIDTH   = 64;
  localparam int POLL_TIMER_WIDTH = 16;

  localparam logic [CSR_ADDR_WIDTH-1:0] HTIF_TOHOST_ADDR = 12'h780;

  // H_* = host transaction, P_* = tohost poll read, C_* = tohost clear write
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_H_REQ  = 3'd1,
    ST_H_RESP = 3'd2,
    ST_H_RET  = 3'd3,
    ST_P_REQ  = 3'd4,
    ST_P_RESP = 3'd5,
    ST_C_REQ  = 3'd6,
    ST_C_RESP = 3'd7
  } htif_state_e;

endpackage

// File: rtl/vscale_htif_poll_timer.sv
// Background tohost poll interval timer.
// Down-counter that starts at POLL_INTERVAL-1, decrements while enabled and
// saturates at zero; zero means a poll is due. Load has priority over enable.
// Ports:
//   hclk, hresetn : clock, asynchronous active-low reset
//   load          : reload POLL_INTERVAL-1
//   en            : decrement (when not already zero)
//   due           : counter is zero
module vscale_htif_poll_timer
  import vscale_htif_host_pkg::*;
#(
  parameter int unsigned POLL_INTERVAL = 64
) (
  input  logic hclk,
  input  logic hresetn,
  input  logic load,
  input  logic en,
  output logic due
);

  localparam logic [POLL_TIMER_WIDTH-1:0] RELOAD = POLL_TIMER_WIDTH'(POLL_INTERVAL - 1);

  logic [POLL_TIMER_WIDTH-1:0] count;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      count <= RELOAD;
    end else if (load) begin
      count <= RELOAD;
    end else if (en && (count != '0)) begin
      count <= count - POLL_TIMER_WIDTH'(1);
    end
  end

  assign due = (count == '0);

endmodule

// File: rtl/vscale_htif_host.sv
// Host-side HTIF master driving the PCR request/response port.
// Serialises host CSR read/write commands onto the PCR channel (one
// outstanding transaction), and in the background polls the tohost CSR,
// latches test completion on the first nonzero value and clears tohost.
// Ports:
//   hclk, hresetn            : clock, asynchronous active-low reset
//   poll_en                  : enable background tohost polling
//   host_cmd_*               : host command (valid/ready, rw, addr, data)
//   host_resp_*              : host response (valid/ready, data)
//   htif_pcr_req_*           : PCR request (valid/ready, rw, addr, data)
//   htif_pcr_resp_*          : PCR response (valid/ready, data)
//   test_done/pass/code      : sticky test completion result
module vscale_htif_host
  import vscale_htif_host_pkg::*;
#(
  parameter int unsigned                POLL_INTERVAL = 64,
  parameter logic [CSR_ADDR_WIDTH-1:0]  TOHOST_ADDR   = HTIF_TOHOST_ADDR
) (
  input  logic                      hclk,
  input  logic                      hresetn,
  input  logic                      poll_en,
  input  logic                      host_cmd_valid,
  output logic                      host_cmd_ready,
  input  logic                      host_cmd_rw,
  input  logic [CSR_ADDR_WIDTH-1:0] host_cmd_addr,
  input  logic [HTIF_PCR_WIDTH-1:0] host_cmd_data,
  output logic                      host_resp_valid,
  input  logic                      host_resp_ready,
  output logic [HTIF_PCR_WIDTH-1:0] host_resp_data,
  output logic                      htif_pcr_req_valid,
  input  logic                      htif_pcr_req_ready,
  output logic                      htif_pcr_req_rw,
  output logic [CSR_ADDR_WIDTH-1:0] htif_pcr_req_addr,
  output logic [HTIF_PCR_WIDTH-1:0] htif_pcr_req_data,
  input  logic                      htif_pcr_resp_valid,
  output logic                      htif_pcr_resp_ready,
  input  logic [HTIF_PCR_WIDTH-1:0] htif_pcr_resp_data,
  output logic                      test_done,
  output logic                      test_pass,
  output logic [30:0]               test_code
);

  htif_state_e state, state_next;

  logic                      cmd_rw_q;
  logic [CSR_ADDR_WIDTH-1:0] cmd_addr_q;
  logic [HTIF_PCR_WIDTH-1:0] cmd_data_q;
  logic [HTIF_PCR_WIDTH-1:0] resp_q;
  logic                      done_q;
  logic                      pass_q;
  logic [30:0]               code_q;

  logic cmd_take;
  logic host_resp_take;
  logic poll_zero;
  logic poll_hit;
  logic poll_due;
  logic timer_load;
  logic timer_en;

  // Dropping poll_en rearms a full interval; an in-flight poll/clear still
  // finishes because the FSM only consults poll_en in IDLE.
  assign timer_load = poll_zero | ~poll_en;
  assign timer_en   = (state == ST_IDLE) & poll_en & ~done_q;

  vscale_htif_poll_timer #(
    .POLL_INTERVAL(POLL_INTERVAL)
  ) u_poll_timer (
    .hclk    (hclk),
    .hresetn (hresetn),
    .load    (timer_load),
    .en      (timer_en),
    .due     (poll_due)
  );

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Host commands take priority over a due poll; the poll stays pending
  // because the timer holds at zero until a zero-result poll reloads it.
  always_comb begin
    state_next     = state;
    cmd_take       = 1'b0;
    host_resp_take = 1'b0;
    poll_zero      = 1'b0;
    poll_hit       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (host_cmd_valid) begin
          cmd_take   = 1'b1;
          state_next = ST_H_REQ;
        end else if (poll_due && poll_en && !done_q) begin
          state_next = ST_P_REQ;
        end
      end
      ST_H_REQ:  if (htif_pcr_req_ready) state_next = ST_H_RESP;
      ST_H_RESP: begin
        if (htif_pcr_resp_valid) begin
          host_resp_take = 1'b1;
          state_next     = ST_H_RET;
        end
      end
      ST_H_RET:  if (host_resp_ready) state_next = ST_IDLE;
      ST_P_REQ:  if (htif_pcr_req_ready) state_next = ST_P_RESP;
      ST_P_RESP: begin
        if (htif_pcr_resp_valid) begin
          if (htif_pcr_resp_data[31:0] == '0) begin
            poll_zero  = 1'b1;
            state_next = ST_IDLE;
          end else begin
            poll_hit   = 1'b1;
            state_next = ST_C_REQ;
          end
        end
      end
      ST_C_REQ:  if (htif_pcr_req_ready) state_next = ST_C_RESP;
      ST_C_RESP: if (htif_pcr_resp_valid) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      cmd_rw_q   <= 1'b0;
      cmd_addr_q <= '0;
      cmd_data_q <= '0;
    end else if (cmd_take) begin
      cmd_rw_q   <= host_cmd_rw;
      cmd_addr_q <= host_cmd_addr;
      cmd_data_q <= host_cmd_data;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      resp_q <= '0;
    end else if (host_resp_take) begin
      resp_q <= htif_pcr_resp_data;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      done_q <= 1'b0;
      pass_q <= 1'b0;
      code_q <= '0;
    end else if (poll_hit) begin
      done_q <= 1'b1;
      pass_q <= (htif_pcr_resp_data[31:0] == 32'd1);
      code_q <= htif_pcr_resp_data[31:1];
    end
  end

  // All handshake outputs decode from state alone, so no valid->ready path.
  always_comb begin
    host_cmd_ready      = (state == ST_IDLE);
    host_resp_valid     = (state == ST_H_RET);
    htif_pcr_req_valid  = 1'b0;
    htif_pcr_req_rw     = 1'b0;
    htif_pcr_req_addr   = '0;
    htif_pcr_req_data   = '0;
    htif_pcr_resp_ready = 1'b0;
    case (state)
      ST_H_REQ: begin
        htif_pcr_req_valid = 1'b1;
        htif_pcr_req_rw    = cmd_rw_q;
        htif_pcr_req_addr  = cmd_addr_q;
        htif_pcr_req_data  = cmd_data_q;
      end
      ST_P_REQ: begin
        htif_pcr_req_valid = 1'b1;
        htif_pcr_req_addr  = TOHOST_ADDR;
      end
      ST_C_REQ: begin
        htif_pcr_req_valid = 1'b1;
        htif_pcr_req_rw    = 1'b1;
        htif_pcr_req_addr  = TOHOST_ADDR;
      end
      ST_H_RESP, ST_P_RESP, ST_C_RESP: htif_pcr_resp_ready = 1'b1;
      default: ;
    endcase
  end

  assign host_resp_data = resp_q;
  assign test_done      = done_q;
  assign test_pass      = pass_q;
  assign test_code      = code_q;

endmodule

// File: tb/tb_vscale_htif_host.sv
// Directed testbench for vscale_htif_host with a behavioural PCR core model.
module tb_vscale_htif_host;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        poll_en;
  logic        host_cmd_valid;
  logic        host_cmd_ready;
  logic        host_cmd_rw;
  logic [11:0] host_cmd_addr;
  logic [63:0] host_cmd_data;
  logic        host_resp_valid;
  logic        host_resp_ready;
  logic [63:0] host_resp_data;
  logic        htif_pcr_req_valid;
  logic        htif_pcr_req_ready;
  logic        htif_pcr_req_rw;
  logic [11:0] htif_pcr_req_addr;
  logic [63:0] htif_pcr_req_data;
  logic        htif_pcr_resp_valid;
  logic        htif_pcr_resp_ready;
  logic [63:0] htif_pcr_resp_data;
  logic        test_done;
  logic        test_pass;
  logic [30:0] test_code;

  vscale_htif_host #(
    .POLL_INTERVAL(8),
    .TOHOST_ADDR  (12'h780)
  ) dut (
    .hclk               (hclk),
    .hresetn            (hresetn),
    .poll_en            (poll_en),
    .host_cmd_valid     (host_cmd_valid),
    .host_cmd_ready     (host_cmd_ready),
    .host_cmd_rw        (host_cmd_rw),
    .host_cmd_addr      (host_cmd_addr),
    .host_cmd_data      (host_cmd_data),
    .host_resp_valid    (host_resp_valid),
    .host_resp_ready    (host_resp_ready),
    .host_resp_data     (host_resp_data),
    .htif_pcr_req_valid (htif_pcr_req_valid),
    .htif_pcr_req_ready (htif_pcr_req_ready),
    .htif_pcr_req_rw    (htif_pcr_req_rw),
    .htif_pcr_req_addr  (htif_pcr_req_addr),
    .htif_pcr_req_data  (htif_pcr_req_data),
    .htif_pcr_resp_valid(htif_pcr_resp_valid),
    .htif_pcr_resp_ready(htif_pcr_resp_ready),
    .htif_pcr_resp_data (htif_pcr_resp_data),
    .test_done          (test_done),
    .test_pass          (test_pass),
    .test_code          (test_code)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic        rw;
    logic [11:0] addr;
    logic [63:0] data;
    int          cycles;   // negedges with req_valid high
    bit          stable;
    int          gap;      // IDLE negedges since previous request started
  } req_rec_t;

  req_rec_t    recs[$];
  logic [63:0] tohost_q[$];
  int          cfg_ready_wait;
  int          cfg_resp_wait;
  logic [63:0] cfg_rd_data;
  logic [63:0] cfg_wr_data;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // PCR core model: all activity on the falling edge.
  int       c_phase;
  int       c_wcnt;
  int       c_idle;
  bit       c_active;
  req_rec_t c_cur;

  initial begin : pcr_core
    htif_pcr_req_ready  = 1'b0;
    htif_pcr_resp_valid = 1'b0;
    htif_pcr_resp_data  = '0;
    c_phase = 0; c_wcnt = 0; c_idle = 0; c_active = 1'b0;
    forever begin
      @(negedge hclk);
      if (!hresetn) begin
        htif_pcr_req_ready  = 1'b0;
        htif_pcr_resp_valid = 1'b0;
        c_phase = 0; c_wcnt = 0; c_active = 1'b0;
      end else begin
        if (host_cmd_ready) c_idle++;
        if (c_phase == 3) begin
          htif_pcr_resp_valid = 1'b0;
          c_phase = 0;
          c_wcnt  = 0;
        end else if (c_phase == 1) begin
          htif_pcr_req_ready = 1'b0;
          recs.push_back(c_cur);
          c_active = 1'b0;
          c_wcnt   = 0;
          if (c_cur.rw) htif_pcr_resp_data = cfg_wr_data;
          else if (c_cur.addr == 12'h780) begin
            if (tohost_q.size() > 0) htif_pcr_resp_data = tohost_q.pop_front();
            else htif_pcr_resp_data = '0;
          end else htif_pcr_resp_data = cfg_rd_data;
          c_phase = 2;
        end
        if (c_phase == 2) begin
          if (c_wcnt >= cfg_resp_wait) begin
            htif_pcr_resp_valid = 1'b1;
            c_phase = 3;
          end else c_wcnt++;
        end else if (c_phase == 0 && htif_pcr_req_valid) begin
          if (!c_active) begin
            c_cur.rw = htif_pcr_req_rw; c_cur.addr = htif_pcr_req_addr;
            c_cur.data = htif_pcr_req_data; c_cur.stable = 1'b1;
            c_cur.cycles = 0; c_cur.gap = c_idle; c_idle = 0; c_active = 1'b1;
          end else if (htif_pcr_req_rw !== c_cur.rw || htif_pcr_req_addr !== c_cur.addr ||
                       htif_pcr_req_data !== c_cur.data) begin
            c_cur.stable = 1'b0;
          end
          c_cur.cycles++;
          if (c_wcnt >= cfg_ready_wait) begin
            htif_pcr_req_ready = 1'b1;
            c_phase = 1;
          end else c_wcnt++;
        end
      end
    end
  end

  // lat = negedges from the command-accepting posedge to seeing host_resp_valid
  task automatic host_txn(input logic rw, input logic [11:0] addr, input logic [63:0] data,
                          output logic [63:0] rdata, output int lat);
    int n;
    @(negedge hclk);
    host_cmd_valid = 1'b1; host_cmd_rw = rw; host_cmd_addr = addr; host_cmd_data = data;
    n = 0;
    while (!host_cmd_ready && n < 200) begin @(negedge hclk); n++; end
    if (!host_cmd_ready) check("cmd_accept_timeout", 0, 1);
    @(negedge hclk);
    host_cmd_valid = 1'b0;
    lat = 1;
    while (!host_resp_valid && lat < 200) begin @(negedge hclk); lat++; end
    if (!host_resp_valid) check("resp_timeout", 0, 1);
    rdata = host_resp_data;
    host_resp_ready = 1'b1;
    @(negedge hclk);
    host_resp_ready = 1'b0;
    check("resp_valid_drop", host_resp_valid, 0);
  endtask

  task automatic reset_pulse();
    @(negedge hclk);
    hresetn = 1'b0;
    repeat (2) @(negedge hclk);
    hresetn = 1'b1;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (!test_done && n < limit) begin @(negedge hclk); n++; end
    check("done_seen", test_done, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [63:0] rd;
    int          lat;
    int          nrec;
    hresetn = 1'b0; poll_en = 1'b0;
    host_cmd_valid = 1'b0; host_cmd_rw = 1'b0; host_cmd_addr = '0; host_cmd_data = '0;
    host_resp_ready = 1'b0;
    cfg_ready_wait = 0; cfg_resp_wait = 0;
    cfg_rd_data = 64'h4000_0100; cfg_wr_data = 64'hCAFE_0005;
    repeat (2) @(negedge hclk);
    check("rst_cmd_ready", host_cmd_ready, 1);
    check("rst_req_valid", htif_pcr_req_valid, 0);
    check("rst_resp_ready", htif_pcr_resp_ready, 0);
    check("rst_host_resp_valid", host_resp_valid, 0);
    check("rst_done", {test_done, test_pass, test_code}, 0);
    hresetn = 1'b1;

    // Host read, two response wait cycles
    recs.delete();
    cfg_resp_wait = 2;
    host_txn(1'b0, 12'h301, 64'h0, rd, lat);
    check("rd_data", rd, 64'h4000_0100);
    check("rd_lat", lat, 5);
    check("rd_nreq", recs.size(), 1);
    if (recs.size() > 0) begin
      check("rd_rw", recs[0].rw, 0);
      check("rd_addr", recs[0].addr, 12'h301);
    end

    // Host write, req_ready held low 3 cycles
    recs.delete();
    cfg_resp_wait = 0; cfg_ready_wait = 3;
    host_txn(1'b1, 12'h780, 64'h5, rd, lat);
    check("wr_resp", rd, 64'hCAFE_0005);
    check("wr_nreq", recs.size(), 1);
    if (recs.size() > 0) begin
      check("wr_fields", {recs[0].rw, recs[0].addr, recs[0].data}, {1'b1, 12'h780, 64'h5});
      check("wr_valid_cycles", recs[0].cycles, 4);
      check("wr_stable", recs[0].stable, 1);
    end
    cfg_ready_wait = 0;

    // Reset while waiting in H_RESP
    cfg_resp_wait = 20;
    @(negedge hclk);
    host_cmd_valid = 1'b1; host_cmd_rw = 1'b0; host_cmd_addr = 12'h305;
    @(negedge hclk);
    host_cmd_valid = 1'b0;
    repeat (2) @(negedge hclk);
    check("mid_resp_ready", htif_pcr_resp_ready, 1);
    #2 hresetn = 1'b0;
    #1;
    check("async_cmd_ready", host_cmd_ready, 1);
    check("async_resp_ready", htif_pcr_resp_ready, 0);
    check("async_req_valid", htif_pcr_req_valid, 0);
    check("async_resp_data", host_resp_data, 0);
    check("async_host_resp_valid", host_resp_valid, 0);
    repeat (2) @(negedge hclk);
    hresetn = 1'b1;
    cfg_resp_wait = 0;
    host_txn(1'b0, 12'h301, 64'h0, rd, lat);
    check("post_rst_data", rd, 64'h4000_0100);
    check("min_round_trip", lat, 3);

    // Polling: tohost reads 0, 0, then 1
    recs.delete();
    tohost_q = '{64'h0, 64'h0, 64'h1};
    poll_en = 1'b1;
    wait_done(300);
    repeat (10) @(negedge hclk);
    check("poll_nreq", recs.size(), 4);
    if (recs.size() >= 4) begin
      check("poll0", {recs[0].rw, recs[0].addr}, {1'b0, 12'h780});
      check("poll1", {recs[1].rw, recs[1].addr}, {1'b0, 12'h780});
      check("poll2", {recs[2].rw, recs[2].addr}, {1'b0, 12'h780});
      check("poll1_gap", recs[1].gap, 8);
      check("poll2_gap", recs[2].gap, 8);
      check("clear_wr", {recs[3].rw, recs[3].addr, recs[3].data}, {1'b1, 12'h780, 64'h0});
    end
    check("pass1", test_pass, 1);
    check("code1", test_code, 0);
    nrec = recs.size();
    repeat (40) @(negedge hclk);
    check("no_poll_after_done", recs.size(), nrec);

    // tohost = 0xB -> fail with code 5
    recs.delete();
    tohost_q = '{64'hB};
    reset_pulse();
    check("rst_clears_done", test_done, 0);
    wait_done(300);
    repeat (10) @(negedge hclk);
    check("pass_b", test_pass, 0);
    check("code_b", test_code, 5);
    check("b_nreq", recs.size(), 2);
    if (recs.size() >= 2)
      check("b_clear_wr", {recs[1].rw, recs[1].addr, recs[1].data}, {1'b1, 12'h780, 64'h0});

    // Host command in the same cycle the first poll becomes due
    tohost_q.delete();
    reset_pulse();
    recs.delete();
    repeat (6) @(negedge hclk);
    host_txn(1'b0, 12'h301, 64'h0, rd, lat);
    check("coll_data", rd, 64'h4000_0100);
    repeat (10) @(negedge hclk);
    check("coll_nreq_min", recs.size() >= 2, 1);
    if (recs.size() >= 2) begin
      check("coll_first_host", {recs[0].rw, recs[0].addr}, {1'b0, 12'h301});
      check("coll_then_poll", {recs[1].rw, recs[1].addr}, {1'b0, 12'h780});
      check("coll_poll_gap", recs[1].gap, 1);
    end
    check("coll_done", test_done, 0);
    poll_en = 1'b0;
    repeat (4) @(negedge hclk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
